conf_load_sequencer: RTL
========================

// Module: conf_load_sequencer
// PURPOSE
//  Bulk-loads the configuration register file from a word-addressed config memory.
//  Drives the file's single write port (wr_en_ext/wr_addr_ext/wr_data_ext).
//  Arbitrates that port between the load FSM and single host writes.
//  Sits between the host/boot controller and the configuration register file.
// PARAMETERS
//  CONF_REGISTERS_SIZE  32  number of config registers (indices 0..SIZE-1)
//  MEM_ADDR_W           16  config memory word-address width
//  DATA_W               32  register/memory data width
// PORTS
//  clk          in   1           single clock, rising edge
//  reset        in   1           asynchronous, active-low
//  start        in   1           load request, sampled only in IDLE
//  base_addr    in   MEM_ADDR_W  memory word address of first config word
//  first_reg    in   5           first destination register index
//  num_regs     in   6           registers to load, 0..32
//  host_req     in   1           host single-write request; hold until granted
//  host_addr    in   32          host destination register index
//  host_data    in   DATA_W      host write data
//  host_gnt     out  1           combinational; host write accepted this cycle
//  mem_rd_en    out  1           config memory read strobe
//  mem_addr     out  MEM_ADDR_W  config memory read address
//  mem_rd_data  in   DATA_W      read data, valid exactly 1 cycle after mem_rd_en
//  wr_en_ext    out  1           register-file write enable (registered)
//  wr_addr_ext  out  32          register-file write index (registered)
//  wr_data_ext  out  DATA_W      register-file write data (registered)
//  busy         out  1           high in READ and WRITE
//  done         out  1           1-cycle pulse at end of a load
//  err          out  1           sticky range error; cleared by reset or accepted start
// BEHAVIOUR
//  Reset: FSM to IDLE. Counters, wr_*, mem_*, busy, done and err all go to 0.
//  Reset mid-load: the load is abandoned, no done pulse, no further writes.
//  FSM: IDLE -> READ -> WRITE -> (READ | DONE) -> IDLE.
//   IDLE:  start=1 latches base_addr, first_reg and num_regs, clears err and k.
//          Range check at acceptance:
//          - num_regs==0 -> DONE, no writes.
//          - first_reg+num_regs > CONF_REGISTERS_SIZE -> err=1, DONE, no writes.
//          - otherwise -> READ.
//   READ:  mem_rd_en=1, mem_addr=base+k (wraps mod 2^MEM_ADDR_W). Next state WRITE.
//   WRITE: captures mem_rd_data; registers write {first_reg+k, data}; k++.
//          Next state DONE if k==num_regs-1, else READ.
//   DONE:  done=1 for exactly one cycle, then IDLE.
//  start outside IDLE (including the DONE cycle) is ignored.
//  Timing, for start accepted in cycle t:
//   - write for register k appears on wr_* at cycle t+3+2k;
//   - done is asserted in cycle t+2N+1, the same cycle as the last write.
//  Arbitration:
//   - host_gnt = host_req && state!=WRITE.
//   - A granted host write appears on wr_* the next cycle.
//   - Loader and host writes never collide: the host uses READ/IDLE/DONE slots,
//     the loader uses the cycle after WRITE.
//   - A host write with host_addr >= CONF_REGISTERS_SIZE is granted (consumed),
//     produces no wr_en_ext, and sets err.
//  wr_en_ext is high only in cycles carrying a write.
//  wr_addr_ext/wr_data_ext hold their last value otherwise.
//  Index arithmetic is 6-bit, zero-extended to 32 on wr_addr_ext.
// STRUCTURE
//  Shared package conf_pkg:
//   - CONF_REGISTERS_SIZE;
//   - state enum {IDLE,READ,WRITE,DONE};
//   - register index constants MEMORY_POINTER_FC=0, FIRST_INDEX_FC_LOG=1,
//     EXECUTION_FRAME_BY_FRAME=2.
//  No sub-module: one FSM, one 6-bit counter and one output register stage
//  in a single file.
// TESTING
//  1. Reset sequence: reset low mid-cycle -> every output is 0 asynchronously,
//     with no clock edge required.
//  2. Normal load: base=0x0100, first_reg=0, num=3, memory words A,B,C -> writes
//     (0,A)@t+3, (1,B)@t+5, (2,C)@t+7; done@t+7; busy t+1..t+6.
//  3. Contention: host_req held during load, addr=5 -> gnt only when state!=WRITE;
//     host write lands between loader writes; no cycle has two writes.
//  4. Bounds: num=0 -> done@t+1, no writes. first_reg=30, num=3 -> err=1,
//     done@t+1, no writes. host_addr=40 -> gnt=1, no wr_en_ext, err=1.
//  5. Edge cases:
//     - base=0xFFFF, num=2 -> mem_addr 0xFFFF then 0x0000;
//     - start while busy -> ignored;
//     - reset during WRITE -> IDLE, no done pulse.

Source files
------------

// File: rtl/conf_load_sequencer_pkg.sv
// Shared definitions for the configuration loader: register file size,
// well-known register indices, FSM state encoding and the range check.
package conf_pkg;

  localparam int unsigned CONF_REGISTERS_SIZE = 32;

  localparam int unsigned MEMORY_POINTER_FC        = 0;
  localparam int unsigned FIRST_INDEX_FC_LOG       = 1;
  localparam int unsigned EXECUTION_FRAME_BY_FRAME = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // True when registers first..first+num-1 all exist in a file of 'size' entries.
  function automatic logic span_fits(input logic [4:0] first,
                                     input logic [5:0] num,
                                     input int unsigned size);
    return (32'(first) + 32'(num)) <= size;
  endfunction

endpackage

// File: rtl/conf_load_sequencer_if.sv
// Bus bundle of the loader: host single-write port, config memory read
// port and the register-file write port. master = sequencer side.
interface conf_load_sequencer_if #(
  parameter int unsigned MEM_ADDR_W = 16,
  parameter int unsigned DATA_W     = 32
);

  logic                  host_req;
  logic [31:0]           host_addr;
  logic [DATA_W-1:0]     host_data;
  logic                  host_gnt;

  logic                  mem_rd_en;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_rd_data;

  logic                  wr_en_ext;
  logic [31:0]           wr_addr_ext;
  logic [DATA_W-1:0]     wr_data_ext;

  modport master (
    input  host_req, host_addr, host_data, mem_rd_data,
    output host_gnt, mem_rd_en, mem_addr, wr_en_ext, wr_addr_ext, wr_data_ext
  );

  modport slave (
    output host_req, host_addr, host_data, mem_rd_data,
    input  host_gnt, mem_rd_en, mem_addr, wr_en_ext, wr_addr_ext, wr_data_ext
  );

endinterface

// File: rtl/conf_load_sequencer.sv
// Bulk loader for the configuration register file. Reads num_regs words
// from config memory starting at base_addr and writes them to registers
// first_reg.. through the file's single write port, which it shares with
// host single writes. The host may use every cycle except WRITE, because
// the loader's own write lands in the cycle after WRITE.
module conf_load_sequencer
  import conf_pkg::state_t, conf_pkg::IDLE, conf_pkg::READ,
         conf_pkg::WRITE, conf_pkg::DONE, conf_pkg::span_fits;
#(
  parameter int unsigned CONF_REGISTERS_SIZE = conf_pkg::CONF_REGISTERS_SIZE,
  parameter int unsigned MEM_ADDR_W          = 16,
  parameter int unsigned DATA_W              = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MEM_ADDR_W-1:0] base_addr,
  input  logic [4:0]            first_reg,
  input  logic [5:0]            num_regs,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  conf_load_sequencer_if.master bus
);

  state_t                state_q, state_d;
  logic [MEM_ADDR_W-1:0] base_q;
  logic [4:0]            first_q;
  logic [5:0]            num_q;
  logic [5:0]            k_q;

  logic                  accept;
  logic                  range_err;
  logic                  host_oob;
  logic                  host_wr;
  logic [5:0]            loader_idx;

  assign loader_idx    = 6'(first_q) + k_q;
  assign bus.host_gnt  = bus.host_req && (state_q != WRITE);
  assign host_oob      = bus.host_gnt && (bus.host_addr >= 32'(CONF_REGISTERS_SIZE));
  assign host_wr       = bus.host_gnt && !host_oob;
  assign bus.mem_rd_en = (state_q == READ);
  assign bus.mem_addr  = (state_q == READ) ? base_q + MEM_ADDR_W'(k_q) : '0;
  assign busy          = (state_q == READ) || (state_q == WRITE);
  assign done          = (state_q == DONE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic, start acceptance and range check.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    range_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (num_regs == '0) begin
            state_d = DONE;
          end else if (!span_fits(first_reg, num_regs, CONF_REGISTERS_SIZE)) begin
            range_err = 1'b1;
            state_d   = DONE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ:    state_d = WRITE;
      WRITE:   state_d = (k_q == num_q - 6'd1) ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load parameters latched at acceptance; word counter advances per WRITE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q  <= '0;
      first_q <= '0;
      num_q   <= '0;
      k_q     <= '0;
    end else if (accept) begin
      base_q  <= base_addr;
      first_q <= first_reg;
      num_q   <= num_regs;
      k_q     <= '0;
    end else if (state_q == WRITE) begin
      k_q <= k_q + 6'd1;
    end
  end

  // Sticky error: an accepted start restarts it from its own range check.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        err <= 1'b0;
    else if (accept)   err <= range_err | host_oob;
    else if (host_oob) err <= 1'b1;
  end

  // Register-file write stage; address/data hold when no write is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.wr_en_ext   <= 1'b0;
      bus.wr_addr_ext <= '0;
      bus.wr_data_ext <= '0;
    end else begin
      bus.wr_en_ext <= 1'b0;
      if (state_q == WRITE) begin
        bus.wr_en_ext   <= 1'b1;
        bus.wr_addr_ext <= 32'(loader_idx);
        bus.wr_data_ext <= bus.mem_rd_data;
      end else if (host_wr) begin
        bus.wr_en_ext   <= 1'b1;
        bus.wr_addr_ext <= bus.host_addr;
        bus.wr_data_ext <= bus.host_data;
      end
    end
  end

endmodule
